// File: rtl/data_memory_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_memory_responder_if
// Purpose  : Load/store port between the CPU datapath and the data memory.
// Revision : 1.0
// ============================================================================
interface data_memory_responder_if;
  logic [1:0]  MEM_write_length;
  logic [31:0] MEM_write_data;
  logic [31:0] MEM_write_address;
  logic [1:0]  MEM_read_length;
  logic        MEM_read_signed;
  logic [31:0] MEM_read_address;
  logic [31:0] MEM_read_data;
  logic        MEM_busy;
  logic        MEM_misaligned;
  logic [31:0] MEM_fault_address;

  modport master (
    output MEM_write_length, MEM_write_data, MEM_write_address,
    output MEM_read_length, MEM_read_signed, MEM_read_address,
    input  MEM_read_data, MEM_busy, MEM_misaligned, MEM_fault_address
  );

  modport slave (
    input  MEM_write_length, MEM_write_data, MEM_write_address,
    input  MEM_read_length, MEM_read_signed, MEM_read_address,
    output MEM_read_data, MEM_busy, MEM_misaligned, MEM_fault_address
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Purpose  : Byte-addressed little-endian data RAM with masked stores,
//            extending loads, post-reset clear and misalignment logging.
// Revision : 1.0
// ============================================================================
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                    SYS_clk,
  input  logic                    SYS_reset,
  data_memory_responder_if.slave  mem
);

  localparam int c_AW = $clog2(DEPTH_WORDS);
  localparam logic [c_AW-1:0] c_LAST = c_AW'(DEPTH_WORDS - 1);
  localparam logic [1:0] c_LEN_NONE = 2'b00;
  localparam logic [1:0] c_LEN_BYTE = 2'b01;
  localparam logic [1:0] c_LEN_HALF = 2'b10;
  localparam logic [1:0] c_LEN_WORD = 2'b11;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [c_AW-1:0]   r_count;
  logic              r_busy;
  logic              r_misaligned;
  logic [31:0]       r_fault_address;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_st_mis;
  logic              w_ld_mis;
  logic              w_st_en;
  logic [c_AW-1:0]   w_widx;
  logic [c_AW-1:0]   w_ridx;
  logic [3:0]        w_st_mask;
  logic [31:0]       w_st_lanes;
  logic [31:0]       w_rword;
  logic [15:0]       w_rlane;
  logic [31:0]       w_rdata;

  // Upper address bits beyond the index are ignored, so the array aliases.
  assign w_widx = mem.MEM_write_address[c_AW+1:2];
  assign w_ridx = mem.MEM_read_address[c_AW+1:2];

  assign w_st_mis = ((mem.MEM_write_length == c_LEN_HALF) && mem.MEM_write_address[0]) ||
                    ((mem.MEM_write_length == c_LEN_WORD) && (mem.MEM_write_address[1:0] != 2'b00));
  assign w_ld_mis = ((mem.MEM_read_length == c_LEN_HALF) && mem.MEM_read_address[0]) ||
                    ((mem.MEM_read_length == c_LEN_WORD) && (mem.MEM_read_address[1:0] != 2'b00));

  assign w_st_en = (r_state == ST_READY) && (mem.MEM_write_length != c_LEN_NONE) && !w_st_mis;

  always_comb begin
    w_st_mask  = 4'b0000;
    w_st_lanes = mem.MEM_write_data;
    case (mem.MEM_write_length)
      c_LEN_BYTE: begin
        w_st_mask  = 4'b0001 << mem.MEM_write_address[1:0];
        w_st_lanes = {4{mem.MEM_write_data[7:0]}};
      end
      c_LEN_HALF: begin
        w_st_mask  = mem.MEM_write_address[1] ? 4'b1100 : 4'b0011;
        w_st_lanes = {2{mem.MEM_write_data[15:0]}};
      end
      c_LEN_WORD: w_st_mask = 4'b1111;
      default:    w_st_mask = 4'b0000;
    endcase
  end

  // Array has no reset; the clear sequencer zeroes it one word per cycle.
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_count] <= '0;
      end else if (w_st_en) begin
        for (int b = 0; b < 4; b++) begin
          if (w_st_mask[b]) begin
            r_mem[w_widx][8*b +: 8] <= w_st_lanes[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_state         <= ST_CLEAR;
      r_count         <= '0;
      r_busy          <= 1'b1;
      r_misaligned    <= 1'b0;
      r_fault_address <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_count <= r_count + 1'b1;
          if (r_count == c_LAST) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        ST_READY: begin
          if (w_st_mis || w_ld_mis) begin
            r_misaligned <= 1'b1;
            // Only the first fault is recorded; the store wins a same-cycle tie.
            if (!r_misaligned) begin
              r_fault_address <= w_st_mis ? mem.MEM_write_address : mem.MEM_read_address;
            end
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign w_rword = r_mem[w_ridx];
  assign w_rlane = 16'(w_rword >> {mem.MEM_read_address[1:0], 3'b000});

  always_comb begin
    w_rdata = '0;
    if ((r_state == ST_READY) && !w_ld_mis) begin
      case (mem.MEM_read_length)
        c_LEN_BYTE: w_rdata = {{24{mem.MEM_read_signed & w_rlane[7]}}, w_rlane[7:0]};
        c_LEN_HALF: w_rdata = {{16{mem.MEM_read_signed & w_rlane[15]}}, w_rlane[15:0]};
        c_LEN_WORD: w_rdata = w_rword;
        default:    w_rdata = '0;
      endcase
    end
  end

  assign mem.MEM_read_data     = w_rdata;
  assign mem.MEM_busy          = r_busy;
  assign mem.MEM_misaligned    = r_misaligned;
  assign mem.MEM_fault_address = r_fault_address;

endmodule
`default_nettype wire

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the CPU data-memory port: a byte-addressed, little-endian RAM that services the length-coded load/store requests issued by the single-cycle datapath. Loads are combinational, with byte/half/word selection and sign or zero extension. Stores commit on the clock edge with byte-lane masking. A post-reset clear sequencer zeroes the array and reports busy. Misaligned accesses are suppressed and logged.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 4
- SYS_clk  in  1  system clock; all state updates on rising edge
- SYS_reset  in  1  synchronous, active-high reset
- MEM_write_length  in  2  00 none, 01 byte, 10 half, 11 word
- MEM_write_data  in  32  store data; low bytes used for byte/half
- MEM_write_address  in  32  store byte address
- MEM_read_length  in  2  00 none, 01 byte, 10 half, 11 word
- MEM_read_signed  in  1  1 = sign-extend byte/half loads, 0 = zero-extend
- MEM_read_address  in  32  load byte address
- MEM_read_data  out  32  load result (combinational)
- MEM_busy  out  1  clear sequence in progress
- MEM_misaligned  out  1  sticky: a misaligned access has occurred
- MEM_fault_address  out  32  address of the first misaligned access

## Operation
- Word index = address[log2(DEPTH_WORDS)+1 : 2]. Higher address bits are ignored, so the array aliases (wrap-around). Byte lane = address[1:0].
- Alignment: byte is always aligned; half requires addr[0]=0; word requires addr[1:0]=00. Length 00 is never misaligned.
- FSM states:
  - CLEAR: entered on any edge with SYS_reset=1; counter set to 0.
  - On each edge with SYS_reset=0 in CLEAR: word[counter] ← 0 and counter++. The edge that writes word DEPTH_WORDS-1 moves the FSM to READY.
  - READY: normal service. The FSM stays in READY until the next reset.
- MEM_busy = 1 in CLEAR, 0 in READY.
- In CLEAR:
  - MEM_read_data = 0.
  - Stores are ignored.
  - Misalignment is not logged.
- Store in READY, aligned, length ≠ 00: on the edge, write only the addressed lanes.
  - byte: lane addr[1:0] ← data[7:0]
  - half: lanes {addr[1],0}/{addr[1],1} ← data[15:0]
  - word: all four lanes
  - Untouched lanes keep their value.
- Load in READY, aligned:
  - byte: lane value, extended per MEM_read_signed
  - half: lanes per addr[1], extended per MEM_read_signed
  - word: the word as stored; MEM_read_signed is ignored
  - length 00 returns 0
- Misaligned store: the write is suppressed.
- Misaligned load: MEM_read_data = 0.
- Misalignment logging (READY only):
  - On the edge, MEM_misaligned ← 1.
  - If MEM_misaligned was 0 before that edge, MEM_fault_address captures the faulting address.
  - If store and load are both misaligned in the same cycle, the store address is captured.
- MEM_misaligned and MEM_fault_address clear only on reset.

## Timing
- Reset values:
  - MEM_busy = 1
  - MEM_misaligned = 0
  - MEM_fault_address = 0
  - MEM_read_data = 0
  - counter = 0
- After SYS_reset deasserts, MEM_busy stays 1 for exactly DEPTH_WORDS cycles, then falls. The CPU must not issue requests while MEM_busy=1.
- Reset asserted mid-clear restarts the sequence from word 0 with the full DEPTH_WORDS cycle count.
- Load latency is 0 cycles: MEM_read_data follows the address, length and signed inputs combinationally.
- Store latency is 1 edge: data is visible to loads in the cycle after the edge.
- Read during write to the same word in one cycle returns the old contents; the new value appears after the edge.
- Flag latency is 1 edge: MEM_misaligned rises in the cycle after the faulting request.

## Test plan
- **Clear sequence.** DEPTH_WORDS=16; hold reset 3 cycles, release.
  - MEM_busy=1 for exactly 16 cycles, then 0.
  - lw 0x3C → 0x00000000.
- **Word store, byte/half loads.** sw 0x87654321 @0x10, then:
  - lw 0x10 → 0x87654321
  - lb 0x11 → 0x00000043
  - lb 0x13 → 0xFFFFFF87
  - lbu 0x13 → 0x00000087
  - lh 0x12 → 0xFFFF8765
  - lhu 0x12 → 0x00008765
- **Lane masking.** After the word store, sh 0xBEEF @0x12 then sb 0xAA @0x10; lw 0x10 → 0xBEEF43AA.
- **Misaligned accesses.**
  - sw 0x11111111 @0x06: lw 0x04 is unchanged, MEM_misaligned=1, MEM_fault_address=0x06.
  - Subsequent lh @0x21: returns 0; MEM_fault_address stays 0x06.
- **Aliasing.** DEPTH_WORDS=16: sw 0xCAFEF00D @0x40 → lw 0x00 returns 0xCAFEF00D.
- **Reset mid-clear / same-cycle read-write.**
  - Reset at clear cycle 7 → MEM_busy is held a further 16 cycles after release.
  - Same-cycle sw 0x1 @0x8 with lw 0x8 returns the old value; the next cycle returns 0x1.
